// File: rtl/msg_frame_pkg.sv
// Shared FSM type, framing constants and sizing helper for the message frame packer.
package msg_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CH_HDR,
    ST_PAYLOAD,
    ST_TRAILER
  } state_t;

  localparam logic [7:0]  CH_MARK    = 8'hA5;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic int words_per_ch(input int bytes);
    return 1 + (bytes + 3) / 4;
  endfunction

endpackage

// File: rtl/msg_crc16_byte.sv
// One-byte step of CRC-16/CCITT (MSB first, no reflection, no final XOR).
module msg_crc16_byte
  import msg_frame_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {data, 8'h00};
    for (int k = 0; k < 8; k++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/msg_frame_packer.sv
// Drains a fixed byte block per channel on each timing pulse and emits one framed word stream.
// Optional MSG_CRC16_EN swaps the byte-sum trailer for a CRC-16/CCITT trailer.
module msg_frame_packer #(
  parameter int          CH_NUM       = 20,
  parameter int          BYTES_PER_CH = 100,
  parameter int          CNT_W        = 16,
  parameter logic [15:0] SYNC_WORD    = 16'hEB90
) (
  input  logic                    sys_clk_i,
  input  logic                    rst_i,
  input  logic                    timing_start_pulse_i,
  output logic [CH_NUM-1:0]       rd_en_o,
  input  logic [CH_NUM*8-1:0]     din_i,
  input  logic [CH_NUM*CNT_W-1:0] data_count_i,
  input  logic [CH_NUM-1:0]       empty_i,
  output logic                    us_wr_clk_o,
  output logic                    us_wr_en_o,
  output logic [31:0]             us_wr_dout_o,
  output logic                    us_wr_last_o,
  input  logic                    us_prog_full_i,
  output logic                    busy_o,
  output logic [15:0]             frame_cnt_o,
  output logic                    overrun_o
);
  import msg_frame_pkg::*;

  localparam logic [16:0] BYTES_W   = 17'(BYTES_PER_CH);
  localparam logic [15:0] BYTES_HDR = 16'(BYTES_PER_CH);
  localparam logic [7:0]  LAST_CH   = 8'(CH_NUM - 1);

  state_t      state_q, state_d;
  logic [7:0]  ch_q;
  logic [16:0] req_q, rcv_q;
  logic        rd_pend_q, pf_q, overrun_q;
  logic [31:0] pack_q, byte_word, chk_word;
  logic [15:0] frame_cnt_q;
  logic [7:0]  din_sel;
  logic        empty_sel, cnt_ok, last_rcv, start_frame, adv_ch, rd_any, ctl_ok;

  always_comb begin
    din_sel   = '0;
    empty_sel = 1'b1;
    cnt_ok    = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_q == 8'(i)) begin
        din_sel   = din_i[i*8 +: 8];
        empty_sel = empty_i[i];
        cnt_ok    = 32'(data_count_i[i*CNT_W +: CNT_W]) >= 32'(BYTES_PER_CH);
      end
    end
  end

  // Control words also wait out the cycle after prog_full drops, so no write follows a full cycle.
  assign ctl_ok      = !us_prog_full_i && !pf_q;
  assign start_frame = (state_q == ST_IDLE) && timing_start_pulse_i;
  assign last_rcv    = rd_pend_q && (rcv_q == BYTES_W - 17'd1);
  assign byte_word   = pack_q | (32'(din_sel) << {~rcv_q[1:0], 3'b000});

  always_comb begin
    state_d      = state_q;
    us_wr_en_o   = 1'b0;
    us_wr_dout_o = '0;
    us_wr_last_o = 1'b0;
    rd_any       = 1'b0;
    adv_ch       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (timing_start_pulse_i) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (ctl_ok) begin
          us_wr_en_o   = 1'b1;
          us_wr_dout_o = {SYNC_WORD, frame_cnt_q};
          state_d      = ST_CH_HDR;
        end
      end
      ST_CH_HDR: begin
        if (ctl_ok) begin
          us_wr_en_o = 1'b1;
          if (cnt_ok) begin
            us_wr_dout_o = {CH_MARK, ch_q, BYTES_HDR};
            state_d      = ST_PAYLOAD;
          end else begin
            us_wr_dout_o = {CH_MARK, ch_q, 16'h0000};
            adv_ch       = 1'b1;
            state_d      = (ch_q == LAST_CH) ? ST_TRAILER : ST_CH_HDR;
          end
        end
      end
      ST_PAYLOAD: begin
        rd_any = !empty_sel && !us_prog_full_i && (req_q != BYTES_W);
        if (rd_pend_q && ((rcv_q[1:0] == 2'b11) || last_rcv)) begin
          us_wr_en_o   = 1'b1;
          us_wr_dout_o = byte_word;
        end
        if (last_rcv) begin
          adv_ch  = 1'b1;
          state_d = (ch_q == LAST_CH) ? ST_TRAILER : ST_CH_HDR;
        end
      end
      ST_TRAILER: begin
        if (ctl_ok) begin
          us_wr_en_o   = 1'b1;
          us_wr_last_o = 1'b1;
          us_wr_dout_o = chk_word;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      rd_en_o[i] = rd_any && (ch_q == 8'(i));
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      req_q       <= '0;
      rcv_q       <= '0;
      rd_pend_q   <= 1'b0;
      pf_q        <= 1'b0;
      overrun_q   <= 1'b0;
      pack_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pf_q      <= us_prog_full_i;
      overrun_q <= timing_start_pulse_i && (state_q != ST_IDLE);
      rd_pend_q <= rd_any;
      if (rd_any) req_q <= req_q + 17'd1;
      if (rd_pend_q) begin
        rcv_q  <= rcv_q + 17'd1;
        pack_q <= us_wr_en_o ? '0 : byte_word;
      end
      if (adv_ch || start_frame) begin
        ch_q   <= start_frame ? 8'd0 : ch_q + 8'd1;
        req_q  <= '0;
        rcv_q  <= '0;
        pack_q <= '0;
      end
      if ((state_q == ST_TRAILER) && us_wr_en_o) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

`ifdef MSG_CRC16_EN
  logic [15:0] crc_q, crc_next;

  msg_crc16_byte u_crc (
    .crc_in (crc_q),
    .data   (din_sel),
    .crc_out(crc_next)
  );

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i)            crc_q <= CRC16_INIT;
    else if (start_frame) crc_q <= CRC16_INIT;
    else if (rd_pend_q)   crc_q <= crc_next;
  end

  assign chk_word = {16'h0000, crc_q};
`else
  logic [31:0] sum_q;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i)            sum_q <= '0;
    else if (start_frame) sum_q <= '0;
    else if (rd_pend_q)   sum_q <= sum_q + 32'(din_sel);
  end

  assign chk_word = sum_q;
`endif

  assign us_wr_clk_o = sys_clk_i;
  assign busy_o      = (state_q != ST_IDLE);
  assign frame_cnt_o = frame_cnt_q;
  assign overrun_o   = overrun_q;

endmodule
